engine_request_ctrl: RTL and testbench

- Initiator side of the engine gen/update handshake; owns the `gen` and `update` request lines and watches `software_stop` and `init` from the engine control FSM.
- Accepts host commands (generate moves / load board) and holds the request until it is acknowledged.
- During update, streams 16 board words into the board RAM write port; during gen, forwards the engine's move stream to the host.
- Releases the request, waits for the engine to return to ready, then reports done or error.

---
 rtl/engine_request_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_engine_request_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_request_ctrl.sv
// engine_request_ctrl: initiator side of the engine gen/update handshake.
// Ports: clk/reset; init/software_stop from the engine FSM; gen/update
// requests; host command (cmd_*), board word stream (upd_*) and board RAM
// write port (brd_wr_*); engine move stream (move_*) forwarded to the host
// (mv_out_*, mv_count); status busy/done/err/err_code.
module engine_request_ctrl #(
    parameter int UPD_WORDS = 16,
    parameter int MOVE_MAX  = 64,
    parameter int TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        software_stop,
    output logic        gen,
    output logic        update,
    input  logic        cmd_valid,
    input  logic        cmd_type,
    output logic        cmd_ready,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    output logic        brd_wr_en,
    output logic [3:0]  brd_wr_addr,
    output logic [15:0] brd_wr_data,
    input  logic        move_valid,
    input  logic [11:0] move_data,
    input  logic        move_last,
    output logic        mv_out_valid,
    output logic [11:0] mv_out_data,
    output logic [6:0]  mv_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_REQ,
        S_XFER,
        S_REL
    } state_t;

    state_t      state_q, state_d;
    logic        init_seen_q, init_seen_d;
    logic        type_q, type_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [3:0]  widx_q, widx_d;
    logic [6:0]  mv_count_q, mv_count_d;
    logic        mv_out_valid_q, mv_out_valid_d;
    logic [11:0] mv_out_data_q, mv_out_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic cmd_fire;
    logic upd_fire;
    logic mv_fire;
    logic timeout_hit;
    logic last_word;
    logic last_move;

    assign cmd_fire  = (state_q == S_IDLE) && cmd_valid;
    assign upd_fire  = (state_q == S_XFER) && type_q && upd_valid;
    assign mv_fire   = (state_q == S_XFER) && !type_q && move_valid;
    assign last_word = (widx_q == 4'(UPD_WORDS - 1));
    // The 64th forwarded move ends the gen even without move_last.
    assign last_move = move_last ||
                       (mv_fire && (mv_count_q == 7'(MOVE_MAX - 1)));
    // cnt_q is 0 in the first cycle of a state, so this fires on the
    // TIMEOUT-th cycle spent in REQ or RELEASE.
    assign timeout_hit = (cnt_q == 10'(TIMEOUT - 1));

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_BOOT;
            init_seen_q    <= 1'b0;
            type_q         <= 1'b0;
            cnt_q          <= '0;
            widx_q         <= '0;
            mv_count_q     <= '0;
            mv_out_valid_q <= 1'b0;
            mv_out_data_q  <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
        end else begin
            state_q        <= state_d;
            init_seen_q    <= init_seen_d;
            type_q         <= type_d;
            cnt_q          <= cnt_d;
            widx_q         <= widx_d;
            mv_count_q     <= mv_count_d;
            mv_out_valid_q <= mv_out_valid_d;
            mv_out_data_q  <= mv_out_data_d;
            done_q         <= done_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT: begin
                if (init_seen_q && !init) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_valid) state_d = S_REQ;
            end
            S_REQ: begin
                if (software_stop)    state_d = S_XFER;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_XFER: begin
                // Engine dropping its ack mid-transfer means it reset.
                if (!software_stop) begin
                    state_d = S_IDLE;
                end else if (type_q) begin
                    if (upd_fire && last_word) state_d = S_REL;
                end else begin
                    if (last_move) state_d = S_REL;
                end
            end
            S_REL: begin
                if (!software_stop)   state_d = S_IDLE;
                else if (timeout_hit) state_d = S_IDLE;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // Counters, latched command, move register and status pulses.
    always_comb begin
        init_seen_d    = init_seen_q;
        type_d         = type_q;
        cnt_d          = (state_d != state_q) ? 10'd0 : cnt_q + 10'd1;
        widx_d         = widx_q;
        mv_count_d     = mv_count_q;
        mv_out_valid_d = mv_fire;
        mv_out_data_d  = mv_fire ? move_data : mv_out_data_q;
        done_d         = (state_q == S_REL) && !software_stop;
        err_d          = 1'b0;
        err_code_d     = err_code_q;

        if ((state_q == S_BOOT) && init) init_seen_d = 1'b1;

        if (cmd_fire) begin
            type_d     = cmd_type;
            widx_d     = '0;
            mv_count_d = '0;
            err_code_d = '0;
        end

        if (upd_fire) widx_d = widx_q + 4'd1;
        if (mv_fire)  mv_count_d = mv_count_q + 7'd1;

        if ((state_q == S_REQ) && !software_stop && timeout_hit) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
        end
        if ((state_q == S_XFER) && !software_stop) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
        end
        if ((state_q == S_REL) && software_stop && timeout_hit) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
        end
    end

    // Outputs. busy covers an active transaction only, so BOOT (the
    // reset state) leaves every output low.
    always_comb begin
        cmd_ready    = (state_q == S_IDLE);
        busy         = (state_q == S_REQ) || (state_q == S_XFER) ||
                       (state_q == S_REL);
        gen          = ((state_q == S_REQ) || (state_q == S_XFER)) && !type_q;
        update       = ((state_q == S_REQ) || (state_q == S_XFER)) && type_q;
        upd_ready    = (state_q == S_XFER) && type_q;
        brd_wr_en    = upd_fire;
        brd_wr_addr  = upd_fire ? widx_q : 4'd0;
        brd_wr_data  = upd_fire ? upd_data : 16'd0;
        mv_out_valid = mv_out_valid_q;
        mv_out_data  = mv_out_data_q;
        mv_count     = mv_count_q;
        done         = done_q;
        err          = err_q;
        err_code     = err_code_q;
    end

endmodule

// File: tb/tb_engine_request_ctrl.sv
// tb_engine_request_ctrl: directed sequence with randomized gaps, data and
// move counts, checked against transaction-level expectations.
module tb_engine_request_ctrl;

    localparam int UPD_WORDS = 16;
    localparam int MOVE_MAX  = 64;
    localparam int TIMEOUT   = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0;
    logic        software_stop = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_type = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_data = '0;
    logic        move_valid = 1'b0;
    logic [11:0] move_data = '0;
    logic        move_last = 1'b0;

    logic        gen, update, cmd_ready, upd_ready, brd_wr_en;
    logic [3:0]  brd_wr_addr;
    logic [15:0] brd_wr_data;
    logic        mv_out_valid;
    logic [11:0] mv_out_data;
    logic [6:0]  mv_count;
    logic        busy, done, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    engine_request_ctrl #(
        .UPD_WORDS(UPD_WORDS),
        .MOVE_MAX (MOVE_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .software_stop(software_stop),
        .gen          (gen),
        .update       (update),
        .cmd_valid    (cmd_valid),
        .cmd_type     (cmd_type),
        .cmd_ready    (cmd_ready),
        .upd_valid    (upd_valid),
        .upd_data     (upd_data),
        .upd_ready    (upd_ready),
        .brd_wr_en    (brd_wr_en),
        .brd_wr_addr  (brd_wr_addr),
        .brd_wr_data  (brd_wr_data),
        .move_valid   (move_valid),
        .move_data    (move_data),
        .move_last    (move_last),
        .mv_out_valid (mv_out_valid),
        .mv_out_data  (mv_out_data),
        .mv_count     (mv_count),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_gen"}, gen, 0);
        chk({tag, "_update"}, update, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_upd_ready"}, upd_ready, 0);
        chk({tag, "_brd_wr_en"}, brd_wr_en, 0);
        chk({tag, "_brd_wr_addr"}, brd_wr_addr, 0);
        chk({tag, "_brd_wr_data"}, brd_wr_data, 0);
        chk({tag, "_mv_out_valid"}, mv_out_valid, 0);
        chk({tag, "_mv_out_data"}, mv_out_data, 0);
        chk({tag, "_mv_count"}, mv_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
    endtask

    task automatic boot();
        init = 1'b0;
        step();
        chk("boot_wait", cmd_ready, 0);
        init = 1'b1;
        step();
        step();
        chk("boot_init_high", cmd_ready, 0);
        init = 1'b0;
        step();
        chk("boot_ready", cmd_ready, 1);
        chk("boot_busy", busy, 0);
        chk("boot_gen", gen, 0);
    endtask

    // Leaves the bench in the first REQ cycle.
    task automatic issue(input bit t);
        cmd_valid = 1'b1;
        cmd_type  = t;
        step();
        cmd_valid = 1'b0;
        chk("req_gen", gen, !t);
        chk("req_update", update, t);
        chk("req_busy", busy, 1);
        chk("req_err_code_clr", err_code, 0);
    endtask

    task automatic run_update(input int abort_word, input bit rel_to,
                              input bit rnd);
        logic [15:0] d;
        int n;
        issue(1'b1);
        step();
        chk("upd_req_hold", update, 1);
        step();
        software_stop = 1'b1;
        step();
        for (int w = 0; w < UPD_WORDS; w++) begin
            repeat ($urandom_range(0, 2)) begin
                upd_valid = 1'b0;
                #1;
                chk("upd_ready_gap", upd_ready, 1);
                chk("wr_en_gap", brd_wr_en, 0);
                step();
            end
            d = rnd ? 16'($urandom) : 16'(w);
            upd_valid = 1'b1;
            upd_data  = d;
            if (w == abort_word) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                upd_valid = 1'b0;
                software_stop = 1'b0;
                return;
            end
            #1;
            chk("wr_en", brd_wr_en, 1);
            chk("wr_addr", brd_wr_addr, w);
            chk("wr_data", brd_wr_data, d);
            chk("upd_hold", update, 1);
            step();
        end
        upd_valid = 1'b0;
        chk("upd_drop", update, 0);
        chk("upd_ready_drop", upd_ready, 0);
        if (rel_to) begin
            n = 0;
            while (busy && n < 2000) begin
                n++;
                step();
            end
            chk("rel_timeout_cycles", n, TIMEOUT);
            chk("rel_timeout_err", err, 1);
            chk("rel_timeout_code", err_code, 2);
            chk("rel_timeout_done", done, 0);
            software_stop = 1'b0;
            step();
            chk("rel_err_pulse", err, 0);
            chk("rel_code_held", err_code, 2);
        end else begin
            for (int c = 0; c < 17; c++) begin
                cmd_valid = (c == 5);
                cmd_type  = 1'b0;
                step();
            end
            cmd_valid = 1'b0;
            chk("rel_no_done", done, 0);
            software_stop = 1'b0;
            step();
            chk("upd_done", done, 1);
            chk("upd_no_err", err, 0);
            chk("upd_idle", cmd_ready, 1);
            step();
            chk("done_pulse", done, 0);
            chk("cmd_ignored", gen, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    task automatic run_gen(input int n_moves, input bit with_last);
        int fwd;
        bit xfer;
        bit exp_v;
        logic [11:0] d;
        fwd  = 0;
        xfer = 1'b1;
        issue(1'b0);
        repeat ($urandom_range(1, 3)) begin
            step();
            chk("gen_req_hold", gen, 1);
        end
        software_stop = 1'b1;
        step();
        for (int i = 0; i < n_moves; i++) begin
            repeat ($urandom_range(0, 1)) begin
                move_valid = 1'b0;
                move_last  = 1'b0;
                step();
                chk("mv_gap", mv_out_valid, 0);
            end
            d = 12'($urandom);
            move_valid = 1'b1;
            move_data  = d;
            move_last  = with_last && (i == n_moves - 1);
            exp_v = xfer;
            if (xfer) begin
                fwd++;
                if (move_last || fwd == MOVE_MAX) xfer = 1'b0;
            end
            step();
            move_valid = 1'b0;
            move_last  = 1'b0;
            chk("mv_valid", mv_out_valid, exp_v);
            if (exp_v) chk("mv_data", mv_out_data, d);
            chk("mv_gen", gen, xfer);
            chk("mv_count", mv_count, fwd);
        end
        repeat (3) step();
        chk("gen_rel_done", done, 0);
        software_stop = 1'b0;
        step();
        chk("gen_done", done, 1);
        chk("gen_final_count", mv_count, fwd);
        chk("gen_idle", cmd_ready, 1);
        step();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) step();
        all_zero("reset");
        reset = 1'b0;
        step();
        all_zero("boot");
        boot();

        run_update(-1, 1'b0, 1'b0);

        run_gen(5, 1'b1);
        run_gen($urandom_range(1, 30), 1'b1);
        run_gen(70, 1'b0);
        chk("gen70_count", mv_count, MOVE_MAX);

        issue(1'b0);
        software_stop = 1'b1;
        step();
        software_stop = 1'b0;
        step();
        chk("abort_err", err, 1);
        chk("abort_code", err_code, 2);
        chk("abort_gen", gen, 0);
        chk("abort_idle", cmd_ready, 1);

        issue(1'($urandom_range(0, 1)));
        n = 0;
        while ((gen || update) && n < 2000) begin
            n++;
            step();
        end
        chk("req_timeout_cycles", n, TIMEOUT);
        chk("req_timeout_err", err, 1);
        chk("req_timeout_code", err_code, 1);
        chk("req_timeout_ready", cmd_ready, 1);
        step();
        chk("req_err_pulse", err, 0);
        chk("req_code_held", err_code, 1);

        run_update(-1, 1'b1, 1'b1);

        run_update(7, 1'b0, 1'b0);
        all_zero("rst_mid");
        repeat (4) begin
            step();
            chk("rst_mid_boot", cmd_ready, 0);
            chk("rst_mid_quiet", done | err, 0);
        end
        boot();
        run_gen(3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
